// File: rtl/pwm_capture.sv
// PWM receiver: synchronizes pwm_in, measures period and high time in clock cycles, flags stuck input.
// Define PWM_CAPTURE_DUTY_EN to add a sequential restoring divider producing duty_pct/duty_valid.
module pwm_capture #(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             stuck_high,
    output logic             stuck_low,
    output logic [6:0]       duty_pct,
    output logic             duty_valid
);

    typedef enum logic [1:0] {
        WAIT_RISE,
        MEAS_HIGH,
        MEAS_LOW
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TIMEOUT_M1 = CNT_W'(TIMEOUT - 1);

    logic             sync1_q;
    logic             s_q;
    logic             s_dly_q;
    logic             rise;
    logic             fall;
    logic             edge_det;
    logic             timeout;

    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic [CNT_W-1:0] idle_q,       idle_d;
    state_t           state_q,      state_d;
    logic [CNT_W-1:0] high_lat_q,   high_lat_d;
    logic [CNT_W-1:0] period_q,     period_d;
    logic [CNT_W-1:0] high_time_q,  high_time_d;
    logic             meas_valid_q, meas_valid_d;
    logic             stuck_high_q, stuck_high_d;
    logic             stuck_low_q,  stuck_low_d;

    always_comb begin
        rise     = s_q & ~s_dly_q;
        fall     = ~s_q & s_dly_q;
        edge_det = rise | fall;
        // An edge in the timeout cycle takes precedence, so no flag is raised then.
        timeout  = ~edge_det && (idle_q == TIMEOUT_M1);
    end

    always_comb begin
        cnt_d = cnt_q;
        if (rise) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        idle_d = idle_q;
        if (edge_det) begin
            idle_d = '0;
        end else if (idle_q != TIMEOUT_C) begin
            idle_d = idle_q + CNT_W'(1);
        end
    end

    always_comb begin
        stuck_high_d = stuck_high_q;
        stuck_low_d  = stuck_low_q;
        if (edge_det) begin
            stuck_high_d = 1'b0;
            stuck_low_d  = 1'b0;
        end else if (timeout) begin
            stuck_high_d = s_q;
            stuck_low_d  = ~s_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        high_lat_d   = high_lat_q;
        period_d     = period_q;
        high_time_d  = high_time_q;
        meas_valid_d = 1'b0;
        if (timeout) begin
            state_d = WAIT_RISE;
        end else begin
            unique case (state_q)
                WAIT_RISE: begin
                    if (rise) begin
                        state_d = MEAS_HIGH;
                    end
                end
                MEAS_HIGH: begin
                    if (fall) begin
                        high_lat_d = cnt_q;
                        state_d    = MEAS_LOW;
                    end
                end
                MEAS_LOW: begin
                    if (rise) begin
                        period_d     = cnt_q;
                        high_time_d  = high_lat_q;
                        meas_valid_d = 1'b1;
                        state_d      = MEAS_HIGH;
                    end
                end
                default: begin
                    state_d = WAIT_RISE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q      <= 1'b0;
            s_q          <= 1'b0;
            s_dly_q      <= 1'b0;
            cnt_q        <= '0;
            idle_q       <= '0;
            state_q      <= WAIT_RISE;
            high_lat_q   <= '0;
            period_q     <= '0;
            high_time_q  <= '0;
            meas_valid_q <= 1'b0;
            stuck_high_q <= 1'b0;
            stuck_low_q  <= 1'b0;
        end else begin
            sync1_q      <= pwm_in;
            s_q          <= sync1_q;
            s_dly_q      <= s_q;
            cnt_q        <= cnt_d;
            idle_q       <= idle_d;
            state_q      <= state_d;
            high_lat_q   <= high_lat_d;
            period_q     <= period_d;
            high_time_q  <= high_time_d;
            meas_valid_q <= meas_valid_d;
            stuck_high_q <= stuck_high_d;
            stuck_low_q  <= stuck_low_d;
        end
    end

    assign period     = period_q;
    assign high_time  = high_time_q;
    assign meas_valid = meas_valid_q;
    assign stuck_high = stuck_high_q;
    assign stuck_low  = stuck_low_q;

`ifdef PWM_CAPTURE_DUTY_EN
    localparam int unsigned NUM_W  = CNT_W + 7;
    localparam int unsigned BITS_W = $clog2(NUM_W + 1);

    // num_q shifts the dividend out of its MSB while quotient bits enter at the LSB.
    logic [NUM_W-1:0]  num_q,        num_d;
    logic [CNT_W-1:0]  rem_q,        rem_d;
    logic [CNT_W-1:0]  div_q,        div_d;
    logic [BITS_W-1:0] bits_q,       bits_d;
    logic              busy_q,       busy_d;
    logic [6:0]        duty_q,       duty_d;
    logic              duty_valid_q, duty_valid_d;
    logic [CNT_W:0]    shifted;
    logic [CNT_W:0]    diff;
    logic              take;

    always_comb begin
        num_d        = num_q;
        rem_d        = rem_q;
        div_d        = div_q;
        bits_d       = bits_q;
        busy_d       = busy_q;
        duty_d       = duty_q;
        duty_valid_d = 1'b0;
        shifted      = {rem_q, num_q[NUM_W-1]};
        diff         = shifted - {1'b0, div_q};
        take         = (shifted >= {1'b0, div_q});
        if (meas_valid_q && (period_q != '0)) begin
            num_d  = NUM_W'(high_time_q) * NUM_W'(100);
            rem_d  = '0;
            div_d  = period_q;
            bits_d = BITS_W'(NUM_W);
            busy_d = 1'b1;
        end else if (busy_q) begin
            rem_d  = take ? diff[CNT_W-1:0] : shifted[CNT_W-1:0];
            num_d  = {num_q[NUM_W-2:0], take};
            bits_d = bits_q - BITS_W'(1);
            if (bits_q == BITS_W'(1)) begin
                busy_d       = 1'b0;
                duty_d       = num_d[6:0];
                duty_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            num_q        <= '0;
            rem_q        <= '0;
            div_q        <= '0;
            bits_q       <= '0;
            busy_q       <= 1'b0;
            duty_q       <= '0;
            duty_valid_q <= 1'b0;
        end else begin
            num_q        <= num_d;
            rem_q        <= rem_d;
            div_q        <= div_d;
            bits_q       <= bits_d;
            busy_q       <= busy_d;
            duty_q       <= duty_d;
            duty_valid_q <= duty_valid_d;
        end
    end

    assign duty_pct   = duty_q;
    assign duty_valid = duty_valid_q;
`else
    assign duty_pct   = '0;
    assign duty_valid = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: directed and random PWM waveforms checked every cycle against an
// event-level model built from edge timestamps (period = rise-to-rise, high = rise-to-fall).
module tb_pwm_capture;

    localparam int unsigned CNT_W   = 32;
    localparam int unsigned TIMEOUT = 1000;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             pwm_in = 1'b0;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             stuck_high;
    logic             stuck_low;
    logic [6:0]       duty_pct;
    logic             duty_valid;

    pwm_capture #(
        .CNT_W  (CNT_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pwm_in    (pwm_in),
        .period    (period),
        .high_time (high_time),
        .meas_valid(meas_valid),
        .stuck_high(stuck_high),
        .stuck_low (stuck_low),
        .duty_pct  (duty_pct),
        .duty_valid(duty_valid)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int mv_count = 0;

    // Model state: levels sampled at recent edges (index 0 = newest) and edge timestamps.
    logic hist[$] = '{1'b0, 1'b0, 1'b0, 1'b0};
    int   e = 0;
    int   last_tr = 0;
    int   rise_t = 0;
    int   fall_t = 0;
    bit   have_rise = 0;
    bit   have_fall = 0;
    int   exp_period = 0;
    int   exp_high = 0;
    bit   exp_mv = 0;
    bit   exp_sh = 0;
    bit   exp_sl = 0;
    int   exp_duty = 0;
    bit   exp_dv = 0;
    bit   pend = 0;
    int   pend_due = 0;
    int   pend_val = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d (edge %0d)", tag, obs, expv, e);
        end
    endtask

    task automatic model_edge();
        e++;
        exp_mv = 0;
        exp_dv = 0;
        if (reset) begin
            hist = '{1'b0, 1'b0, 1'b0, 1'b0};
            last_tr = e;
            have_rise = 0;
            have_fall = 0;
            exp_period = 0;
            exp_high = 0;
            exp_sh = 0;
            exp_sl = 0;
            exp_duty = 0;
            pend = 0;
            return;
        end
        hist.push_front(pwm_in);
        void'(hist.pop_back());
        if (pend && e == pend_due) begin
            exp_duty = pend_val;
            exp_dv = 1;
            pend = 0;
        end
        // The DUT reacts to a level change two edges after it is first sampled.
        if (hist[2] != hist[3]) begin
            last_tr = e;
            exp_sh = 0;
            exp_sl = 0;
            if (hist[2]) begin
                if (have_rise && have_fall) begin
                    exp_period = e - rise_t;
                    exp_high = fall_t - rise_t;
                    exp_mv = 1;
                    if (exp_period != 0) begin
                        pend = 1;
                        pend_due = e + CNT_W + 8;
                        pend_val = (exp_high * 100) / exp_period;
                    end
                end
                have_rise = 1;
                have_fall = 0;
                rise_t = e;
            end else if (have_rise) begin
                have_fall = 1;
                fall_t = e;
            end
        end else if (e - last_tr == TIMEOUT) begin
            exp_sh = hist[2];
            exp_sl = !hist[2];
            have_rise = 0;
            have_fall = 0;
        end
    endtask

    task automatic check_outputs();
        chk("meas_valid", meas_valid, exp_mv);
        chk("period", period, exp_period);
        chk("high_time", high_time, exp_high);
        chk("stuck_high", stuck_high, exp_sh);
        chk("stuck_low", stuck_low, exp_sl);
`ifdef PWM_CAPTURE_DUTY_EN
        chk("duty_pct", duty_pct, exp_duty);
        chk("duty_valid", duty_valid, exp_dv);
`else
        chk("duty_pct_off", duty_pct, 0);
        chk("duty_valid_off", duty_valid, 0);
`endif
    endtask

    task automatic tick(input logic lvl);
        pwm_in = lvl;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
        if (meas_valid === 1'b1) mv_count++;
    endtask

    task automatic hold(input logic lvl, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) tick(lvl);
    endtask

    task automatic pwm(input int unsigned per, input int unsigned hi, input int unsigned n);
        for (int unsigned p = 0; p < n; p++) begin
            hold(1'b1, hi);
            hold(1'b0, per - hi);
        end
    endtask

    int mv_base;

    initial begin
        // Reset and reset values
        reset = 1'b1;
        hold(1'b0, 3);
        chk("rst_period", period, 0);
        chk("rst_stuck_low", stuck_low, 0);
        reset = 1'b0;

        // 100/80 for three periods: only the 2nd and 3rd rises report
        pwm(100, 80, 3);
        chk("p100_count", mv_count, 2);
        chk("p100_period", period, 100);
        chk("p100_high", high_time, 80);
`ifdef PWM_CAPTURE_DUTY_EN
        chk("p100_duty", duty_pct, 80);
`endif

        // 10/3 then 50/25: boundary capture reports the old waveform, then the new one
        pwm(10, 3, 5);
        chk("p10_period", period, 10);
        chk("p10_high", high_time, 3);
        pwm(50, 25, 1);
`ifdef PWM_CAPTURE_DUTY_EN
        chk("p10_duty", duty_pct, 30);
`endif
        pwm(50, 25, 2);
        chk("p50_period", period, 50);
        chk("p50_high", high_time, 25);
`ifdef PWM_CAPTURE_DUTY_EN
        chk("p50_duty", duty_pct, 50);
`endif

        // Random waveforms
        for (int unsigned k = 0; k < 6; k++) begin
            int unsigned per;
            int unsigned hi;
            per = $urandom_range(300, 4);
            hi = $urandom_range(per - 1, 1);
            pwm(per, hi, 3);
        end

        // Stuck low after reset: flag appears exactly TIMEOUT cycles after reset
        reset = 1'b1;
        tick(1'b0);
        reset = 1'b0;
        mv_base = mv_count;
        hold(1'b0, TIMEOUT - 1);
        chk("sl_before", stuck_low, 0);
        tick(1'b0);
        chk("sl_at", stuck_low, 1);
        chk("sl_high", stuck_high, 0);
        chk("sl_no_meas", mv_count, mv_base);
        pwm(60, 20, 3);
        chk("sl_cleared", stuck_low, 0);
        chk("sl_recover_count", mv_count, mv_base + 2);

        // Stuck high inside MEAS_HIGH: values held, two rises needed afterwards
        pwm(40, 10, 2);
        hold(1'b1, TIMEOUT + 100);
        chk("sh_set", stuck_high, 1);
        chk("sh_period_held", period, 40);
        chk("sh_high_held", high_time, 10);
        hold(1'b0, 30);
        chk("sh_cleared", stuck_high, 0);
        mv_base = mv_count;
        pwm(40, 10, 3);
        chk("sh_recover_count", mv_count, mv_base + 2);

        // Reset pulse in the middle of a high phase
        pwm(30, 20, 2);
        hold(1'b1, 10);
        reset = 1'b1;
        tick(1'b1);
        reset = 1'b0;
        chk("mr_period", period, 0);
        chk("mr_high", high_time, 0);
        chk("mr_mv", meas_valid, 0);
        hold(1'b1, 10);
        hold(1'b0, 20);
        pwm(30, 20, 3);

        // Edges landing exactly on the timeout cycle, high then low
        hold(1'b0, 5);
        pwm(1200, TIMEOUT, 3);
        chk("edge_to_sh", stuck_high, 0);
        chk("edge_to_period", period, 1200);
        chk("edge_to_high", high_time, TIMEOUT);
        pwm(TIMEOUT + 100, 100, 3);
        chk("edge_to_sl", stuck_low, 0);
        chk("edge_to_period2", period, TIMEOUT + 100);
        hold(1'b0, 60);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
